mac_lane_array: RTL
===================

Name: mac_lane_array

Overview:
- Parametrised successor to the single-lane MAC: LANES parallel multipliers feed a registered adder tree and a frame-based accumulator.
- Per-lane signed/unsigned mode.
- Valid/ready handshake on both sides; one result per frame, closed by in_last.
- Sits between the image/weight buffers and the neuron activation stage.

Parameters:
- IN_WIDTH, 8, width of each image and weight element.
- LANES, 4, number of parallel multiply lanes (power of 2, >=1).
- ACC_WIDTH, 24, accumulator and result width (must be >= 2*IN_WIDTH+$clog2(LANES)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  beat is the last of the current frame.
- signed_mode  in  1  1: operands two's complement; 0: unsigned. Sampled per beat.
- img_in  in  LANES*IN_WIDTH  packed image elements, lane 0 in LSBs.
- weight_in  in  LANES*IN_WIDTH  packed weights, lane 0 in LSBs.
- flush  in  1  synchronous abort: drop in-flight beats and clear the accumulator.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_WIDTH  frame dot-product result.
- out_ovf  out  1  overflow occurred in this frame (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async): all pipeline valid bits, accumulator, out_data, out_valid, out_ovf = 0. in_ready = 1 after reset.
- Stall: advance = !(out_valid && !out_ready).
  - in_ready = advance. A beat is accepted when in_valid && in_ready.
  - When advance=0, every pipeline register holds its value.
- Stage 1 (P), cycle t+1:
  - Per lane, register the product of the extended operands, 2*IN_WIDTH bits.
  - Operands are sign-extended if signed_mode, else zero-extended.
  - Register valid, last and mode alongside the products.
- Stage 2 (S), cycle t+2:
  - Register the sum of LANES products, width 2*IN_WIDTH+$clog2(LANES).
  - The sum is signed or unsigned per the beat's mode.
- Stage 3 (A), cycle t+3:
  - ext = sum extended to ACC_WIDTH per mode.
  - Non-last beat: acc <= acc + ext.
  - Last beat: out_data <= acc + ext; out_valid <= 1; acc <= 0. The next frame starts clean with no bubble.
- Latency: last beat accepted at cycle t gives out_valid high at t+3.
- Throughput: 1 beat/cycle while out_ready=1.
- Output handshake:
  - out_data/out_valid are held stable until out_valid && out_ready.
  - out_valid falls the cycle after the transfer unless a new last completes in the same advancing cycle; in that case out_data is replaced and out_valid stays high.
- Single-beat frame (in_last on the first beat): result = that beat's sum.
- Mode changing within a frame: each beat is extended per its own mode. No error is flagged.
- Arithmetic without saturation: modulo 2^ACC_WIDTH wrap.
- flush = 1 in a cycle:
  - Clears the P/S valid bits and acc.
  - Does not affect a result already in out_data/out_valid.
  - A beat presented in the same cycle is not accepted: in_ready = advance && !flush.
- Flush takes priority over the stall.
- Reset asserted mid-frame: immediate clear, and partial results are lost.

Optional Feature:
- Macro MAC_LANE_SAT_EN.
- Defined:
  - Accumulator updates saturate: signed to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], unsigned to [0, 2^ACC_WIDTH-1].
  - The overflow check uses one extra guard bit.
  - A frame-local sticky flag is set on any saturation. It is presented as out_ovf with the result and clears with acc.
- Not defined:
  - Wrap arithmetic as above.
  - out_ovf tied to 0.
  - No guard logic is synthesised.

Test Plan:
- Unsigned 3-beat frame, LANES=4, all img=255, weight=255, out_ready=1 -> out_valid one cycle, 3 cycles after the last beat is accepted; out_data = 3*4*65025 = 780300; out_ovf=0.
- Signed single beat: lanes img={-128,127,-1,2}, weight={-128,127,5,-3}, in_last=1 -> out_data = 16384+16129-5-6 = 32502.
- Back-to-back frames: 2-beat frame, sums 10 and 20, then immediately a 1-beat frame, sum 7, no idle cycles -> results 30 then 7, no interference.
- Backpressure: out_ready=0 with a result pending and another frame streaming -> in_ready drops; out_data held at the first result; after out_ready=1, second result arrives intact with no beat lost or duplicated.
- Flush mid-frame: two beats (sum 100 each) accepted, flush, then a 1-beat frame of sum 5 -> out_data=5.
- Saturation: MAC_LANE_SAT_EN, ACC_WIDTH=18, unsigned, 5 beats of all 255*255 on 4 lanes -> out_data=262143, out_ovf=1. Without the macro -> out_data = 1300500 mod 262144 = 251924, out_ovf=0.

Source files
------------

// File: rtl/mac_lane_array.sv
// mac_lane_array: LANES parallel multipliers, a registered lane sum and a frame accumulator
// with valid/ready on both sides. Define MAC_LANE_SAT_EN for saturating accumulation and out_ovf.
module mac_lane_array #(
  parameter int IN_WIDTH  = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic                      signed_mode,
  input  logic [LANES*IN_WIDTH-1:0] img_in,
  input  logic [LANES*IN_WIDTH-1:0] weight_in,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic                      out_ovf
);
  localparam int PW = 2 * IN_WIDTH;
  localparam int SW = PW + $clog2(LANES);

  logic                 w_advance;
  logic [PW-1:0]        w_prod   [LANES];
  logic [PW-1:0]        r_p_prod [LANES];
  logic                 r_p_valid, r_p_last, r_p_mode;
  logic [SW-1:0]        w_sum, r_s_sum;
  logic                 r_s_valid, r_s_last, r_s_mode;
  logic [ACC_WIDTH-1:0] w_ext_sum, w_acc_next, r_acc, r_out_data;
  logic                 r_out_valid;

  // The whole pipeline freezes only while a finished result waits for the consumer.
  assign w_advance = !(r_out_valid && !out_ready);
  assign in_ready  = w_advance && !flush;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [IN_WIDTH:0] w_a, w_b;
      assign w_a = {signed_mode & img_in[gi*IN_WIDTH+IN_WIDTH-1], img_in[gi*IN_WIDTH +: IN_WIDTH]};
      assign w_b = {signed_mode & weight_in[gi*IN_WIDTH+IN_WIDTH-1], weight_in[gi*IN_WIDTH +: IN_WIDTH]};
      // The low 2*IN_WIDTH bits hold the exact product in either mode.
      assign w_prod[gi] = PW'(w_a * w_b);
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++)
      w_sum = w_sum + (r_p_mode ? SW'($signed(r_p_prod[i])) : SW'(r_p_prod[i]));
  end

  assign w_ext_sum = r_s_mode ? ACC_WIDTH'($signed(r_s_sum)) : ACC_WIDTH'(r_s_sum);

`ifdef MAC_LANE_SAT_EN
  logic [ACC_WIDTH:0] w_guard;
  logic               w_sat;
  logic               r_ovf, r_out_ovf;

  always_comb begin
    w_guard = r_s_mode ? ({r_acc[ACC_WIDTH-1], r_acc} + {w_ext_sum[ACC_WIDTH-1], w_ext_sum})
                       : ({1'b0, r_acc} + {1'b0, w_ext_sum});
    w_sat      = r_s_mode ? (w_guard[ACC_WIDTH] != w_guard[ACC_WIDTH-1]) : w_guard[ACC_WIDTH];
    w_acc_next = w_guard[ACC_WIDTH-1:0];
    if (w_sat) begin
      if (!r_s_mode)               w_acc_next = '1;
      else if (w_guard[ACC_WIDTH]) w_acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                         w_acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf     <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (flush) begin
      r_ovf <= 1'b0;
    end else if (w_advance && r_s_valid) begin
      if (r_s_last) begin
        r_out_ovf <= r_ovf | w_sat;
        r_ovf     <= 1'b0;
      end else begin
        r_ovf <= r_ovf | w_sat;
      end
    end
  end

  assign out_ovf = r_out_ovf;
`else
  assign w_acc_next = r_acc + w_ext_sum;
  assign out_ovf    = 1'b0;
`endif

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_advance && !flush) begin
      for (int i = 0; i < LANES; i++) r_p_prod[i] <= w_prod[i];
      r_p_last <= in_last;
      r_p_mode <= signed_mode;
      r_s_sum  <= w_sum;
      r_s_last <= r_p_last;
      r_s_mode <= r_p_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_valid   <= 1'b0;
      r_s_valid   <= 1'b0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (flush) begin
        r_p_valid <= 1'b0;
        r_s_valid <= 1'b0;
        r_acc     <= '0;
      end else if (w_advance) begin
        r_p_valid <= in_valid;
        r_s_valid <= r_p_valid;
        if (r_s_valid) begin
          if (r_s_last) begin
            r_out_data  <= w_acc_next;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
          end else begin
            r_acc <= w_acc_next;
          end
        end
      end
    end
  end
endmodule
